// File: rtl/memory_responder.sv
// memory_responder: single-port word-addressed memory with a request/ready
// handshake, fixed multi-cycle latency and a memory data register (MDR).
module memory_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  mem_busy,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // State and registered outputs
  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    rd_q;
  logic                    wr_q;
  logic                    busy;
  logic                    ready;
  logic                    err;
  logic [DATA_WIDTH-1:0]   mdr;

  // Next-state / control
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    busy_nxt;
  logic                    ready_nxt;
  logic                    err_nxt;
  logic                    capture;
  logic                    do_op;

  // Operation being completed this edge (latched request, or the live
  // request when a single-cycle latency completes on acceptance)
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [DATA_WIDTH-1:0]   op_data;
  logic                    op_rd;
  logic                    op_wr;
  logic                    op_oor;
  logic                    op_err;
  logic                    mem_we;
  logic                    mdr_load;
  logic [DEPTH_LOG2-1:0]   op_idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   storage [DEPTH];

  // Next-state, countdown and operation decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    capture   = 1'b0;
    do_op     = 1'b0;
    op_addr   = addr_q;
    op_data   = wdata_q;
    op_rd     = rd_q;
    op_wr     = wr_q;

    case (state)
      IDLE, RESP: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
        if (mem_read || mem_write) begin
          capture = 1'b1;
          cnt_nxt = CNT_LOAD;
          if (LATENCY > 1) begin
            state_nxt = WAIT;
            busy_nxt  = 1'b1;
          end else begin
            op_addr   = mem_addr;
            op_data   = mem_write_data;
            op_rd     = mem_read;
            op_wr     = mem_write;
            do_op     = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        busy_nxt = 1'b1;
        if (cnt == '0) begin
          do_op     = 1'b1;
          state_nxt = RESP;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // Any address bit above the storage index marks the access illegal
    op_oor    = (op_addr >> DEPTH_LOG2) != '0;
    op_err    = op_oor || (op_rd && op_wr);
    op_idx    = op_addr[DEPTH_LOG2-1:0];
    rd_word   = storage[op_idx];
    // Simultaneous strobes behave as a read, so only a pure write stores
    mem_we    = do_op && op_wr && !op_rd && !op_oor;
    mdr_load  = do_op && op_rd;
    ready_nxt = do_op;
    err_nxt   = do_op && op_err;
  end

  // State register, request latch, MDR and registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      mdr     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      ready <= ready_nxt;
      err   <= err_nxt;
      if (capture) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_write_data;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
      end
      if (mdr_load) begin
        mdr <= op_oor ? '0 : rd_word;
      end
    end
  end

  // Storage array; contents survive reset, but reset suppresses a pending write
  always_ff @(posedge CLK) begin
    if (!reset && mem_we) begin
      storage[op_idx] <= op_data;
    end
  end

  assign mem_busy     = busy;
  assign mem_ready    = ready;
  assign mem_err      = err;
  assign mem_data_out = mdr;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder at default parameters (LATENCY = 2).
module tb_memory_responder;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 2;

  logic          CLK;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_read;
  logic          mem_write;
  logic          mem_busy;
  logic          mem_ready;
  logic          mem_err;
  logic [DW-1:0] mem_data_out;

  int n_vec  = 0;
  int n_miss = 0;

  memory_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(10),
    .LATENCY   (LAT)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_busy      (mem_busy),
    .mem_ready     (mem_ready),
    .mem_err       (mem_err),
    .mem_data_out  (mem_data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every vector and reports miscompares
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic busy, input logic ready,
                            input logic err, input logic [DW-1:0] dout);
    check({tag, ".busy"},  32'(mem_busy),     32'(busy));
    check({tag, ".ready"}, 32'(mem_ready),    32'(ready));
    check({tag, ".err"},   32'(mem_err),      32'(err));
    check({tag, ".dout"},  32'(mem_data_out), 32'(dout));
  endtask

  // Present a request, then walk the WAIT cycles with scrambled inputs
  // (optionally holding a write strobe) and check the response cycle.
  // Returns in the RESP cycle with strobes low, ready for a back-to-back call.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic hold, input logic exp_err, input logic [DW-1:0] exp_dout);
    mem_read       = rd;
    mem_write      = wr;
    mem_addr       = addr;
    mem_write_data = data;
    tick();
    for (int i = 0; i < int'(LAT); i++) begin
      check({tag, ".wait_busy"},  32'(mem_busy),  32'(1));
      check({tag, ".wait_ready"}, 32'(mem_ready), 32'(0));
      mem_addr       = 16'h0007;
      mem_write_data = 16'hDEAD;
      mem_write      = hold;
      mem_read       = 1'b0;
      tick();
    end
    check_outs({tag, ".resp"}, 1'b0, 1'b1, exp_err, exp_dout);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idle(input string tag, input logic [DW-1:0] exp_dout);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
    check_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, exp_dout);
  endtask

  initial begin
    reset          = 1'b1;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;

    // Reset with random strobes: outputs cleared, nothing accepted
    for (int i = 0; i < 2; i++) begin
      mem_read       = 1'($urandom);
      mem_write      = 1'($urandom);
      mem_addr       = 16'($urandom);
      mem_write_data = 16'($urandom);
      tick();
      check_outs("reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    reset = 1'b0;
    idle("post_reset", 16'h0000);

    // Write then read back-to-back from RESP
    do_req("wr_beef", 1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
    do_req("rd_beef", 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, 16'hBEEF);
    idle("hold_beef", 16'hBEEF);

    // Input hold: WAIT-cycle garbage (write strobe to addr 7) must be ignored
    do_req("wr_0707", 1'b0, 1'b1, 16'h0007, 16'h0707, 1'b0, 1'b0, 16'hBEEF);
    idle("i1", 16'hBEEF);
    do_req("wr_1111", 1'b0, 1'b1, 16'h0003, 16'h1111, 1'b1, 1'b0, 16'hBEEF);
    do_req("rd_1111", 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h1111);
    idle("i2", 16'h1111);
    do_req("rd_0707", 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0, 16'h0707);
    idle("i3", 16'h0707);

    // Out of range write/read, in-range location untouched
    do_req("wr_0a0a", 1'b0, 1'b1, 16'h0000, 16'h0A0A, 1'b0, 1'b0, 16'h0707);
    do_req("wr_oor",  1'b0, 1'b1, 16'h0400, 16'h5555, 1'b0, 1'b1, 16'h0707);
    do_req("rd_oor",  1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 1'b1, 16'h0000);
    do_req("rd_0a0a", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0A0A);
    do_req("rd_oor8", 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, 16'h0000);
    idle("i4", 16'h0000);

    // Both strobes: behaves as a read with error, storage unchanged
    do_req("rdwr",    1'b1, 1'b1, 16'h0003, 16'h9999, 1'b0, 1'b1, 16'h1111);
    idle("i5", 16'h1111);
    do_req("rd_0a0b", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0A0A);
    do_req("rd_3",    1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h1111);
    idle("i6", 16'h1111);

    // Reset during WAIT aborts the write
    do_req("wr_0001", 1'b0, 1'b1, 16'h0005, 16'h0001, 1'b0, 1'b0, 16'h1111);
    idle("i7", 16'h1111);
    mem_write      = 1'b1;
    mem_addr       = 16'h0005;
    mem_write_data = 16'h7777;
    tick();
    check_outs("abort_wait", 1'b1, 1'b0, 1'b0, 16'h1111);
    mem_write = 1'b0;
    reset     = 1'b1;
    tick();
    check_outs("abort_rst", 1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    idle("abort_a", 16'h0000);
    idle("abort_b", 16'h0000);
    do_req("rd_5", 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0001);
    idle("end", 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
